// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter
//   Shares one single-port on-chip RAM Wishbone slave between two masters:
//   master 0 (instruction bus) and master 1 (data bus). Round-robin
//   arbitration. The grant is held for the whole bus cycle, i.e. while the
//   granted master keeps cyc high. A watchdog aborts transfers that the
//   slave never acknowledges.
//
// Parameters
//   TIMEOUT  cycles of s_stb_o without s_ack_i before abort (0 = no watchdog)
//   TW       watchdog counter width, 2^TW > TIMEOUT
//
// Ports
//   clk_i, rst_i                       clock, synchronous active-high reset
//   mX_cyc_i/stb_i/we_i/adr_i/sel_i/dat_i   master X request side
//   mX_dat_o, mX_ack_o, mX_err_o       master X response side
//   s_cyc_o/stb_o/we_o/adr_o/sel_o/dat_o    slave request side
//   s_ack_i, s_dat_i                   slave response side
//   gnt_o                              one-hot current grant, 00 when idle
module wb_ram_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [TW-1:0] wdog, wdog_nxt;
  logic          req0, req1;
  logic          timeout;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Only meaningful while granted; wdog is held at zero in IDLE.
  assign timeout = (TIMEOUT != 0) && (state != IDLE) && (wdog == TO_VAL);

  // Read data is broadcast; only the ack tells a master the data is its own.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      wdog  <= wdog_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    wdog_nxt  = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_sel_o   = '0;
    s_dat_o   = '0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_err_o  = 1'b0;
    gnt_o     = 2'b00;

    case (state)
      IDLE: begin
        // On a tie the master that did not win last time gets the bus.
        if (req0 && (!req1 || last)) begin
          state_nxt = GNT0;
          last_nxt  = 1'b0;
        end else if (req1) begin
          state_nxt = GNT1;
          last_nxt  = 1'b1;
        end
      end

      GNT0: begin
        gnt_o   = 2'b01;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_sel_o = m0_sel_i;
        s_dat_o = m0_dat_i;
        if (timeout) begin
          // Abort: pull the slave off the bus and report the error instead.
          s_cyc_o   = 1'b0;
          s_stb_o   = 1'b0;
          m0_err_o  = 1'b1;
          state_nxt = IDLE;
        end else begin
          m0_ack_o = s_ack_i;
          if (m0_stb_i && !s_ack_i) begin
            wdog_nxt = wdog + TW'(1);
          end
          // Grant survives stb gaps; only dropping cyc releases the RAM.
          if (!m0_cyc_i) begin
            state_nxt = IDLE;
          end
        end
      end

      GNT1: begin
        gnt_o   = 2'b10;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_sel_o = m1_sel_i;
        s_dat_o = m1_dat_i;
        if (timeout) begin
          s_cyc_o   = 1'b0;
          s_stb_o   = 1'b0;
          m1_err_o  = 1'b1;
          state_nxt = IDLE;
        end else begin
          m1_ack_o = s_ack_i;
          if (m1_stb_i && !s_ack_i) begin
            wdog_nxt = wdog + TW'(1);
          end
          if (!m1_cyc_i) begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
module tb_wb_ram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
  logic [3:0]  m0_sel_i = '0;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
  logic [3:0]  m1_sel_i = '0;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic [1:0]  gnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wb_ram_arbiter #(.TIMEOUT(16), .TW(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .gnt_o(gnt_o)
  );

  // RAM slave model: registered ack, ack every other cycle under continuous stb.
  logic        ram_ack = 1'b0;
  logic [31:0] ram_rd  = '0;
  logic [31:0] mem [16];
  bit          ack_en  = 1'b1;
  bit          use_ram = 1'b0;
  logic        tb_ack  = 1'b0;

  always @(posedge clk_i) begin
    if (s_cyc_o && s_stb_o && !ram_ack && ack_en) begin
      ram_ack <= 1'b1;
      ram_rd  <= mem[s_adr_o[5:2]];
      if (s_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (s_sel_o[b]) mem[s_adr_o[5:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
        end
      end
    end else begin
      ram_ack <= 1'b0;
    end
  end

  assign s_ack_i = use_ram ? ram_ack : tb_ack;
  assign s_dat_i = use_ram ? ram_rd  : 32'hDEAD_BEEF;

  // in = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}; cs = {s_cyc, s_stb}; ak = {m0_ack, m1_ack}
  typedef struct {
    logic [4:0]  in;
    logic [1:0]  gnt;
    logic [1:0]  cs;
    logic [31:0] adr;
    logic [1:0]  ak;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
      m0_adr_i = adr; m0_sel_i = sel; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
      m1_adr_i = adr; m1_sel_i = sel; m1_dat_i = dat;
    end
  endtask

  // Single transfer by master m from an idle bus against the RAM model.
  task automatic xfer(input int m, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input string tag, output logic [31:0] rd);
    int gnt_at, ack_at, nack, oth;
    logic [31:0] adr_seen;
    logic [3:0]  sel_seen;
    logic [1:0]  my_gnt;
    my_gnt = (m == 0) ? 2'b01 : 2'b10;
    gnt_at = -1; ack_at = -1; nack = 0; oth = 0;
    adr_seen = '0; sel_seen = '0; rd = '0;
    @(negedge clk_i);
    set_m(m, 1'b1, 1'b1, we, adr, sel, dat);
    for (int i = 1; i <= 20 && ack_at < 0; i++) begin
      @(negedge clk_i); #1;
      if (gnt_at < 0 && gnt_o == my_gnt) begin
        gnt_at = i; adr_seen = s_adr_o; sel_seen = s_sel_o;
      end
      if ((m == 0) ? m1_ack_o : m0_ack_o) oth++;
      if ((m == 0) ? m0_ack_o : m1_ack_o) begin
        nack++; ack_at = i;
        rd = (m == 0) ? m0_dat_o : m1_dat_o;
        set_m(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      end
    end
    if (ack_at < 0) set_m(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk_i); #1;
    chk({tag, " gnt_latency"}, 64'(gnt_at), 64'd1);
    chk({tag, " s_adr"}, adr_seen, adr);
    chk({tag, " s_sel"}, sel_seen, sel);
    chk({tag, " ack_latency"}, 64'(ack_at), 64'd2);
    chk({tag, " release_gnt_acks_other"}, {gnt_o, m0_ack_o, m1_ack_o, 32'(oth)}, 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int n1, m0_early, stb_at, err_at, nerr, ack0, m1g_at;
    logic [1:0] cs_err, gnt_after;

    tv[0]  = '{5'b00000, 2'b00, 2'b00, 32'h00, 2'b00};
    tv[1]  = '{5'b11000, 2'b00, 2'b00, 32'h00, 2'b00};
    tv[2]  = '{5'b11000, 2'b01, 2'b11, 32'h10, 2'b00};
    tv[3]  = '{5'b11001, 2'b01, 2'b11, 32'h10, 2'b10};
    tv[4]  = '{5'b00110, 2'b01, 2'b00, 32'h10, 2'b00};
    tv[5]  = '{5'b00110, 2'b00, 2'b00, 32'h00, 2'b00};
    tv[6]  = '{5'b00111, 2'b10, 2'b11, 32'h20, 2'b01};
    tv[7]  = '{5'b11100, 2'b10, 2'b10, 32'h20, 2'b00};
    tv[8]  = '{5'b11000, 2'b10, 2'b00, 32'h20, 2'b00};
    tv[9]  = '{5'b11110, 2'b00, 2'b00, 32'h00, 2'b00};
    tv[10] = '{5'b11111, 2'b01, 2'b11, 32'h10, 2'b10};
    tv[11] = '{5'b00110, 2'b01, 2'b00, 32'h10, 2'b00};
    tv[12] = '{5'b11110, 2'b00, 2'b00, 32'h00, 2'b00};
    tv[13] = '{5'b11110, 2'b10, 2'b11, 32'h20, 2'b00};
    tv[14] = '{5'b11001, 2'b10, 2'b00, 32'h20, 2'b01};
    tv[15] = '{5'b00001, 2'b00, 2'b00, 32'h00, 2'b00};

    // Reset state
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset_outputs", {gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 64'd0);
    rst_i = 1'b0;

    // Cycle-by-cycle arbitration vectors with the slave ack driven directly
    m0_adr_i = 32'h10; m0_we_i = 1'b0; m0_sel_i = 4'hF; m0_dat_i = 32'h0;
    m1_adr_i = 32'h20; m1_we_i = 1'b1; m1_sel_i = 4'h3; m1_dat_i = 32'h1234;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, tb_ack} = tv[i].in;
      #1;
      chk($sformatf("vec%0d", i),
          {gnt_o, s_cyc_o, s_stb_o, s_adr_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o},
          {tv[i].gnt, tv[i].cs, tv[i].adr, tv[i].ak, 2'b00});
    end
    tb_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk_i);
    use_ram = 1'b1;

    // Single accesses through the RAM model, including a byte-lane write
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hCAFE_F00D, "m0_wr10", rd);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, "m0_rd10", rd);
    chk("m0_rd10 data", rd, 32'hCAFE_F00D);
    xfer(0, 1'b1, 32'h40, 4'hF, 32'h1122_3344, "m0_wr40", rd);
    xfer(1, 1'b1, 32'h40, 4'b0100, 32'h00AB_0000, "m1_bytewr", rd);
    xfer(0, 1'b0, 32'h40, 4'hF, 32'h0, "m0_rd40", rd);
    chk("byte_merge data", rd, 32'h11AB_3344);

    // Master 1 locks the RAM across 4 writes while master 0 waits
    @(negedge clk_i);
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h30, 4'hF, 32'h5555_0000);
    @(negedge clk_i);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    n1 = 0; m0_early = 0;
    for (int i = 0; i < 30 && n1 < 4; i++) begin
      @(negedge clk_i); #1;
      if (gnt_o[0]) m0_early++;
      if (m1_ack_o) begin
        n1++;
        if (n1 == 4) set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      end
    end
    chk("hold m1_acks", 64'(n1), 64'd4);
    chk("hold m0_no_grant", 64'(m0_early), 64'd0);
    @(negedge clk_i); #1;
    chk("hold release_idle", gnt_o, 2'b00);
    @(negedge clk_i); #1;
    chk("hold m0_granted", {gnt_o, s_adr_o}, {2'b01, 32'h10});
    @(negedge clk_i); #1;
    chk("hold m0_ack", {m0_ack_o, m1_ack_o}, 2'b10);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk_i);

    // Watchdog: slave never acknowledges
    ack_en = 1'b0;
    @(negedge clk_i);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    stb_at = -1; err_at = -1; nerr = 0; ack0 = 0; m1g_at = -1;
    cs_err = 2'b11; gnt_after = 2'b11;
    for (int i = 1; i <= 40 && m1g_at < 0; i++) begin
      @(negedge clk_i); #1;
      if (stb_at < 0 && s_stb_o) stb_at = i;
      if (m0_ack_o) ack0++;
      if (err_at >= 0 && i == err_at + 1) gnt_after = gnt_o;
      if (gnt_o == 2'b10) begin
        m1g_at = i;
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      end
      if (m0_err_o) begin
        nerr++;
        if (err_at < 0) begin
          err_at = i;
          cs_err = {s_cyc_o, s_stb_o};
          set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
          set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        end
      end
    end
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("wdog err_delay", 64'(err_at - stb_at), 64'd16);
    chk("wdog err_count", 64'(nerr), 64'd1);
    chk("wdog slave_forced_off", cs_err, 2'b00);
    chk("wdog no_ack", 64'(ack0), 64'd0);
    chk("wdog idle_after", gnt_after, 2'b00);
    chk("wdog m1_granted", 64'(m1g_at - err_at), 64'd2);
    ack_en = 1'b1;
    repeat (2) @(negedge clk_i);

    // Reset during a granted write, then a tie goes to master 0
    @(negedge clk_i);
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h44, 4'hF, 32'h1234_5678);
    @(negedge clk_i); #1;
    chk("rst pre_gnt", gnt_o, 2'b10);
    rst_i = 1'b1;
    @(negedge clk_i); #1;
    chk("rst abandon", {gnt_o, s_cyc_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 64'd0);
    rst_i = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    @(negedge clk_i); #1;
    chk("rst tie_m0", {gnt_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, {2'b01, 4'b0000});
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_ram_arbiter.md
# wb_ram_arbiter

Two-master Wishbone arbiter that shares the single-port on-chip RAM slave between the processor instruction bus (master 0) and data bus (master 1). It sits between the two master ports and the RAM wrapper. It grants one master at a time with round-robin fairness and holds the grant for the whole bus cycle. A bus watchdog terminates transfers the slave never acknowledges.

## Interface
Parameters:
- `TIMEOUT`, default 16: cycles of `s_stb_o` without `s_ack_i` before the watchdog aborts the transfer; 0 disables the watchdog.
- `TW`, default 5: width of the watchdog counter; must satisfy `2^TW > TIMEOUT`.

Ports (mX = m0, m1):
- `clk_i`  in  1  system clock; all logic is on its rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `mX_cyc_i`, `mX_stb_i`, `mX_we_i`  in  1 each  master X Wishbone controls.
- `mX_adr_i`  in  32  master X byte address.
- `mX_sel_i`  in  4  master X byte enables.
- `mX_dat_i`  in  32  master X write data.
- `mX_dat_o`  out  32  read data; equals `s_dat_i` for both masters.
- `mX_ack_o`  out  1  acknowledge, routed only to the granted master.
- `mX_err_o`  out  1  one-cycle error pulse on watchdog abort.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  slave controls.
- `s_adr_o`  out  32  slave address.
- `s_sel_o`  out  4  slave byte enables.
- `s_dat_o`  out  32  slave write data.
- `s_ack_i`  in  1  slave acknowledge.
- `s_dat_i`  in  32  slave read data.
- `gnt_o`  out  2  one-hot current grant (bit X = master X); 00 when idle.

## Operation
States:
- IDLE, GNT0, GNT1 (registered).
- `last` register: index of the most recently granted master.
- `wdog` counter: TW bits.

Requests: `reqX = mX_cyc_i & mX_stb_i`.

IDLE:
- Only reqX set -> GNTX.
- Both set -> grant the master not equal to `last`.
- Neither set -> stay in IDLE.
- On entering GNTX, `last <= X`.

GNTX:
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_adr_o`, `s_sel_o`, `s_dat_o` = master X signals (combinational mux).
- `mX_ack_o = s_ack_i`.
- The other master's ack and err are 0.
- The grant is held while `mX_cyc_i` = 1, including cycles where stb drops. This lets a master lock the RAM for back-to-back or read-modify-write sequences.
- `mX_cyc_i` = 0 -> IDLE next edge. The other master is never granted directly.

IDLE outputs:
- All slave outputs 0, all acks 0, `gnt_o` = 00.

Watchdog (TIMEOUT != 0):
- In GNTX, `wdog` increments each cycle with `s_stb_o` = 1 and `s_ack_i` = 0.
- `wdog` clears on `s_ack_i`, on `s_stb_o` = 0, and in IDLE.
- When `wdog` == TIMEOUT: `mX_err_o` = 1 for that cycle, `s_cyc_o` and `s_stb_o` are forced to 0, and the state goes to IDLE.

Reset values (rst_i = 1):
- state IDLE, `last` = 1 (master 0 wins the first tie), `wdog` = 0.
- Hence all outputs listed under IDLE are 0, and both `mX_err_o` = 0.
- Reset mid-transfer abandons the transfer; no ack or err is issued.

## Timing
- Arbitration latency: request seen in IDLE at edge N -> granted signals present on the slave in cycle N+1.
- With the RAM's registered ack, a single access completes with ack in cycle N+2.
- Ack and read data pass combinationally from the slave to the granted master; no added latency.
- Release costs one IDLE cycle. A master that drops cyc and immediately re-requests competes under round-robin in that IDLE cycle.
- A master that holds cyc/stb continuously sees the RAM's ack-every-other-cycle pattern unchanged.
- Watchdog abort: err is asserted in the cycle where `wdog` reaches TIMEOUT, i.e. TIMEOUT cycles after stb is first presented without ack. The state is IDLE on the next cycle.
- Simultaneous release and new request by the other master in the same cycle: the request is seen in IDLE on the following cycle.

## Test plan
- Master 0 read alone at adr 0x10: the slave shows adr 0x10 one cycle after the request; `m0_ack_o` pulses once with the RAM's data; `m1_ack_o` stays 0; `gnt_o` = 01 then 00.
- Both masters request continuously from reset with single transfers: grants alternate m0, m1, m0, m1; each granted master gets exactly one ack per transfer.
- Master 1 holds cyc across 4 writes while master 0 requests: master 0 receives no grant until `m1_cyc_i` falls; master 0 is then granted after one IDLE cycle.
- Slave ack tied to 0 with TIMEOUT = 16: `m0_err_o` pulses for exactly one cycle 16 cycles after stb; `s_cyc_o` falls and `m0_ack_o` never rises; master 1 can then be granted.
- `rst_i` asserted during a granted write: next cycle `gnt_o` = 00, `s_cyc_o` = 0, no ack or err; after release, a tie grants master 0.
- Byte write with `m1_sel_i` = 0100 and data 0x00AB0000, then read back: `s_sel_o` = 0100 during the write; the read returns byte 2 = 0xAB with other bytes unchanged.
